// File: rtl/ad9228_train_ctrl_if.sv
// SPI configuration write handshake between the training controller and the ADC SPI master.
// The controller holds cfg_req with a stable address and data until the master pulses cfg_ack.
interface ad9228_train_ctrl_if;
    logic        cfg_req;
    logic [12:0] cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        cfg_ack;

    modport master (output cfg_req, cfg_addr, cfg_wdata, input cfg_ack);
    modport slave  (input cfg_req, cfg_addr, cfg_wdata, output cfg_ack);
endinterface

// File: rtl/ad9228_train_ctrl.sv
// AD9228 link training: test-pattern config over SPI, per-channel word-boundary slip search, restore normal mode.
// Latency: SETTLE_CYCLES after config plus per-channel search; cfg_req holds until cfg_ack, start ignored while busy.
module ad9228_train_ctrl #(
    parameter int                          NUM_CH        = 4,
    parameter int                          DATA_WIDTH    = 12,
    parameter logic [DATA_WIDTH-1:0]       TRAIN_PATTERN = 12'hA5C,
    parameter logic [12:0]                 TEST_REG      = 13'h00D,
    parameter logic [7:0]                  TEST_VAL      = 8'h48,
    parameter logic [7:0]                  NORM_VAL      = 8'h00,
    parameter logic [12:0]                 XFER_REG      = 13'h0FF,
    parameter logic [7:0]                  XFER_VAL      = 8'h01,
    parameter int                          SETTLE_CYCLES = 64,
    parameter int                          MATCH_COUNT   = 16,
    parameter int                          MAX_SLIPS     = DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           data_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   des_data,
    output logic [NUM_CH-1:0]              slip,
    ad9228_train_ctrl_if.master            cfg,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [NUM_CH-1:0]              ch_locked
);

    localparam int MC_W = $clog2(MATCH_COUNT + 1);
    localparam int SC_W = $clog2(MAX_SLIPS + 1);
    localparam int HO_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [MC_W-1:0] MATCH_LAST  = MC_W'(MATCH_COUNT - 1);
    localparam logic [SC_W-1:0] SLIP_LIMIT  = SC_W'(MAX_SLIPS);
    localparam logic [HO_W-1:0] HOLD_LOAD   = HO_W'(SETTLE_CYCLES);
    localparam logic [HO_W-1:0] SETTLE_LAST = HO_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WR_TEST, WR_XFER1, SETTLE, TRAIN, WR_NORM, WR_XFER2, FINISH
    } state_t;

    state_t              state_q, state_d;
    logic                cfg_req_q;
    logic [12:0]         cfg_addr_q, wr_addr;
    logic [7:0]          cfg_wdata_q, wr_data;
    logic                is_wr, acked, clr;
    logic                fail_q;
    logic [HO_W-1:0]     settle_q;

    logic [MC_W-1:0]     match_q  [NUM_CH];
    logic [SC_W-1:0]     slips_q  [NUM_CH];
    logic [HO_W-1:0]     hold_q   [NUM_CH];
    logic [NUM_CH-1:0]   locked_q, failed_q, slip_q, cmp_en;

    assign acked = cfg_req_q & cfg.cfg_ack;
    assign clr   = (state_q == IDLE) & start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        is_wr   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            IDLE:     if (start) state_d = WR_TEST;
            WR_TEST: begin
                is_wr   = 1'b1;
                wr_addr = TEST_REG;
                wr_data = TEST_VAL;
                if (acked) state_d = WR_XFER1;
            end
            WR_XFER1: begin
                is_wr   = 1'b1;
                wr_addr = XFER_REG;
                wr_data = XFER_VAL;
                if (acked) state_d = SETTLE;
            end
            SETTLE:   if (settle_q == SETTLE_LAST) state_d = TRAIN;
            TRAIN:    if (&(locked_q | failed_q)) state_d = WR_NORM;
            WR_NORM: begin
                is_wr   = 1'b1;
                wr_addr = TEST_REG;
                wr_data = NORM_VAL;
                if (acked) state_d = WR_XFER2;
            end
            WR_XFER2: begin
                is_wr   = 1'b1;
                wr_addr = XFER_REG;
                wr_data = XFER_VAL;
                if (acked) state_d = FINISH;
            end
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request rises one cycle after entering a write state, so cfg_req is always low for a cycle between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_req_q   <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            settle_q    <= '0;
            fail_q      <= 1'b0;
        end else begin
            cfg_req_q   <= is_wr & ~acked;
            cfg_addr_q  <= wr_addr;
            cfg_wdata_q <= wr_data;
            settle_q    <= (state_q == SETTLE) ? settle_q + 1'b1 : '0;
            if (clr) begin
                fail_q <= 1'b0;
            end else if (state_q == WR_XFER2 && acked) begin
                fail_q <= |failed_q;
            end
        end
    end

    always_comb begin
        cmp_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cmp_en[c] = (state_q == TRAIN) && data_valid && (hold_q[c] == '0)
                        && !locked_q[c] && !failed_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= '0;
            failed_q <= '0;
            slip_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                match_q[c] <= '0;
                slips_q[c] <= '0;
                hold_q[c]  <= '0;
            end
        end else begin
            slip_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (hold_q[c] != '0) hold_q[c] <= hold_q[c] - 1'b1;
                if (clr) begin
                    match_q[c]  <= '0;
                    slips_q[c]  <= '0;
                    hold_q[c]   <= '0;
                    locked_q[c] <= 1'b0;
                    failed_q[c] <= 1'b0;
                end else if (cmp_en[c]) begin
                    if (des_data[c*DATA_WIDTH +: DATA_WIDTH] == TRAIN_PATTERN) begin
                        match_q[c] <= match_q[c] + 1'b1;
                        if (match_q[c] == MATCH_LAST) locked_q[c] <= 1'b1;
                    end else if (slips_q[c] != SLIP_LIMIT) begin
                        slip_q[c]  <= 1'b1;
                        slips_q[c] <= slips_q[c] + 1'b1;
                        match_q[c] <= '0;
                        hold_q[c]  <= HOLD_LOAD;
                    end else begin
                        failed_q[c] <= 1'b1;
                    end
                end
            end
        end
    end

    assign cfg.cfg_req   = cfg_req_q;
    assign cfg.cfg_addr  = cfg_addr_q;
    assign cfg.cfg_wdata = cfg_wdata_q;
    assign slip          = slip_q;
    assign busy          = (state_q != IDLE) && (state_q != FINISH);
    assign done          = (state_q == FINISH);
    assign fail          = fail_q;
    assign ch_locked     = locked_q;

endmodule

// File: tb/tb_ad9228_train_ctrl.sv
// Directed bench for ad9228_train_ctrl: SPI ack responder, ADC model with slip-driven rotation, event monitor.
module tb_ad9228_train_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, data_valid;
    logic [47:0] des_data;
    logic [3:0]  slip, ch_locked;
    logic        busy, done, fail;

    ad9228_train_ctrl_if cfg_if();

    ad9228_train_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .data_valid(data_valid), .des_data(des_data),
        .slip(slip), .cfg(cfg_if.master), .busy(busy), .done(done), .fail(fail), .ch_locked(ch_locked)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          init_rot [4];
    logic [3:0]  stuck;
    int          ack_dly;
    logic        clr_req;
    int          slips [4], last_slip [4], min_gap [4];
    int          done_cnt, done_t, stab_err;
    logic [20:0] wr_log [$];
    logic [20:0] cap;
    logic        prev_req;
    int          base_len;

    function automatic logic [11:0] rotr(input logic [11:0] x, input int n);
        logic [23:0] d;
        d = {x, x};
        return d[n +: 12];
    endfunction

    // Monitor: owns all event counters; samples on the falling edge.
    initial begin
        prev_req = 1'b0; cap = '0; done_cnt = 0; done_t = 0; stab_err = 0;
        for (int c = 0; c < 4; c++) begin slips[c] = 0; last_slip[c] = -1; min_gap[c] = 1000000; end
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req) begin
                done_cnt = 0; stab_err = 0; wr_log.delete();
                for (int c = 0; c < 4; c++) begin slips[c] = 0; last_slip[c] = -1; min_gap[c] = 1000000; end
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (slip[c]) begin
                        slips[c]++;
                        if (last_slip[c] >= 0 && cyc - last_slip[c] < min_gap[c]) min_gap[c] = cyc - last_slip[c];
                        last_slip[c] = cyc;
                    end
                end
                if (done) begin done_cnt++; done_t = cyc; end
                if (cfg_if.cfg_req) begin
                    if (!prev_req) begin
                        cap = {cfg_if.cfg_addr, cfg_if.cfg_wdata};
                        wr_log.push_back(cap);
                    end else if ({cfg_if.cfg_addr, cfg_if.cfg_wdata} != cap) begin
                        stab_err++;
                    end
                end
            end
            prev_req = cfg_if.cfg_req;
        end
    end

    // ADC model: each slip rotates the channel word back by one bit.
    initial begin
        int r;
        data_valid = 1'b0; des_data = '0;
        forever begin
            @(posedge clk); #1;
            data_valid = (cyc % 4 == 0);
            for (int c = 0; c < 4; c++) begin
                r = init_rot[c] - slips[c];
                r = ((r % 12) + 12) % 12;
                des_data[c*12 +: 12] = stuck[c] ? 12'h000 : rotr(12'hA5C, r);
            end
        end
    end

    // SPI master model: acknowledges ack_dly cycles into each request.
    initial begin
        int n;
        n = 0;
        cfg_if.cfg_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            cfg_if.cfg_ack = 1'b0;
            if (cfg_if.cfg_req) begin
                n++;
                if (n == ack_dly) cfg_if.cfg_ack = 1'b1;
            end else begin
                n = 0;
            end
        end
    end

    task automatic setup(input int rot2, input logic [3:0] stk, input int dly);
        for (int c = 0; c < 4; c++) init_rot[c] = 0;
        init_rot[2] = rot2;
        stuck = stk;
        ack_dly = dly;
    endtask

    task automatic start_run(output int st);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        while (cyc % 4 != 1) begin @(posedge clk); #1; end
        st = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin @(posedge clk); #1; n++; end
        checks++;
        if (done_cnt == 0) begin failures++; $display("FAIL done_timeout: no done pulse within %0d cycles", n); end
        repeat (10) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (slip !== 4'h0)             begin failures++; $display("FAIL reset_slip: got %h want 0", slip); end
        if (cfg_if.cfg_req !== 1'b0 || cfg_if.cfg_addr !== 13'h0 || cfg_if.cfg_wdata !== 8'h0) begin
            failures++; $display("FAIL reset_cfg: req=%b addr=%h wdata=%h want 0/0/0", cfg_if.cfg_req, cfg_if.cfg_addr, cfg_if.cfg_wdata);
        end
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: busy=%b done=%b want 0/0", busy, done); end
        if (fail !== 1'b0)             begin failures++; $display("FAIL reset_fail: got %b want 0", fail); end
        if (ch_locked !== 4'h0)        begin failures++; $display("FAIL reset_locked: got %h want 0", ch_locked); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_writes(input string name);
        logic [20:0] exp_w [4];
        exp_w[0] = {13'h00D, 8'h48}; exp_w[1] = {13'h0FF, 8'h01};
        exp_w[2] = {13'h00D, 8'h00}; exp_w[3] = {13'h0FF, 8'h01};
        checks += 2;
        if (wr_log.size() != 4) begin failures++; $display("FAIL %s_wr_count: got %0d want 4", name, wr_log.size()); end
        if (stab_err != 0)      begin failures++; $display("FAIL %s_cfg_stable: %0d changes while cfg_req high, want 0", name, stab_err); end
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_w[i]) begin
                failures++; $display("FAIL %s_wr%0d: got addr=%h data=%h want addr=%h data=%h", name, i,
                                     wr_log[i][20:8], wr_log[i][7:0], exp_w[i][20:8], exp_w[i][7:0]);
            end
        end
    endtask

    task automatic test_aligned();
        int st;
        setup(0, 4'b0000, 3);
        start_run(st);
        wait_done();
        base_len = done_t - st;
        check_writes("aligned");
        checks += 4;
        if (slips[0] + slips[1] + slips[2] + slips[3] != 0) begin failures++; $display("FAIL aligned_slips: got %0d want 0", slips[0] + slips[1] + slips[2] + slips[3]); end
        if (ch_locked !== 4'hF) begin failures++; $display("FAIL aligned_locked: got %h want f", ch_locked); end
        if (fail !== 1'b0)      begin failures++; $display("FAIL aligned_fail: got %b want 0", fail); end
        if (done_cnt != 1 || busy !== 1'b0) begin failures++; $display("FAIL aligned_done: done pulses=%0d busy=%b want 1/0", done_cnt, busy); end
    endtask

    task automatic test_misaligned();
        int st;
        setup(5, 4'b0000, 3);
        start_run(st);
        wait_done();
        checks += 4;
        if (slips[2] != 5) begin failures++; $display("FAIL mis_slip2: got %0d pulses want 5", slips[2]); end
        if (slips[0] + slips[1] + slips[3] != 0) begin failures++; $display("FAIL mis_other_slips: got %0d want 0", slips[0] + slips[1] + slips[3]); end
        if (min_gap[2] < 64) begin failures++; $display("FAIL mis_slip_gap: min gap %0d want >=64", min_gap[2]); end
        if (ch_locked !== 4'hF || fail !== 1'b0) begin failures++; $display("FAIL mis_locked: locked=%h fail=%b want f/0", ch_locked, fail); end
    endtask

    task automatic test_dead();
        int st;
        setup(0, 4'b0010, 3);
        start_run(st);
        wait_done();
        repeat (200) begin @(posedge clk); #1; end
        check_writes("dead");
        checks += 4;
        if (slips[1] != 12) begin failures++; $display("FAIL dead_slips: got %0d want 12", slips[1]); end
        if (ch_locked !== 4'b1101) begin failures++; $display("FAIL dead_locked: got %b want 1101", ch_locked); end
        if (fail !== 1'b1) begin failures++; $display("FAIL dead_fail: got %b want 1", fail); end
        if (done_cnt != 1) begin failures++; $display("FAIL dead_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_handshake();
        int st;
        setup(0, 4'b0000, 200);
        start_run(st);
        repeat (150) begin @(posedge clk); #1; end
        checks += 4;
        if (cfg_if.cfg_req !== 1'b1 || cfg_if.cfg_addr !== 13'h00D || cfg_if.cfg_wdata !== 8'h48) begin
            failures++; $display("FAIL hs_hold: req=%b addr=%h wdata=%h want 1/00d/48", cfg_if.cfg_req, cfg_if.cfg_addr, cfg_if.cfg_wdata);
        end
        if (wr_log.size() != 1) begin failures++; $display("FAIL hs_no_advance: %0d requests want 1", wr_log.size()); end
        if (ch_locked !== 4'h0 || fail !== 1'b0) begin failures++; $display("FAIL hs_cleared: locked=%h fail=%b want 0/0", ch_locked, fail); end
        if (busy !== 1'b1) begin failures++; $display("FAIL hs_busy: got %b want 1", busy); end
        wait_done();
        check_writes("hs");
        checks++;
        if (ch_locked !== 4'hF) begin failures++; $display("FAIL hs_locked: got %h want f", ch_locked); end
    endtask

    task automatic test_reset_mid();
        int st, n, act;
        setup(5, 4'b0000, 3);
        start_run(st);
        n = 0;
        while (slips[2] == 0 && n < 3000) begin @(posedge clk); #1; n++; end
        checks++;
        if (slips[2] == 0) begin failures++; $display("FAIL rmid_first_slip: none within %0d cycles", n); end
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 3;
        if (slip !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
            failures++; $display("FAIL rmid_ctrl: slip=%h busy=%b done=%b fail=%b want 0", slip, busy, done, fail);
        end
        if (cfg_if.cfg_req !== 1'b0 || cfg_if.cfg_addr !== 13'h0 || cfg_if.cfg_wdata !== 8'h0) begin
            failures++; $display("FAIL rmid_cfg: req=%b addr=%h wdata=%h want 0", cfg_if.cfg_req, cfg_if.cfg_addr, cfg_if.cfg_wdata);
        end
        if (ch_locked !== 4'h0) begin failures++; $display("FAIL rmid_locked: got %h want 0", ch_locked); end
        act = 0;
        repeat (30) begin @(posedge clk); #1; if (busy || cfg_if.cfg_req || slip != 0) act++; end
        checks++;
        if (act != 0) begin failures++; $display("FAIL rmid_idle: %0d active cycles want 0", act); end
        setup(0, 4'b0000, 3);
        start_run(st);
        wait_done();
        check_writes("rmid_rerun");
        checks++;
        if (ch_locked !== 4'hF) begin failures++; $display("FAIL rmid_rerun_locked: got %h want f", ch_locked); end
    endtask

    task automatic test_start_busy();
        int st, n;
        setup(0, 4'b0000, 3);
        start_run(st);
        n = 0;
        while (!(wr_log.size() == 2 && !cfg_if.cfg_req) && n < 200) begin @(posedge clk); #1; n++; end
        repeat (10) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check_writes("sbusy");
        checks += 2;
        if (done_t - st != base_len) begin failures++; $display("FAIL sbusy_len: run took %0d cycles want %0d", done_t - st, base_len); end
        if (done_cnt != 1) begin failures++; $display("FAIL sbusy_done: got %0d pulses want 1", done_cnt); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clr_req = 1'b0;
        setup(0, 4'b0000, 3);
        base_len = 0;
        test_reset();
        test_aligned();
        test_misaligned();
        test_dead();
        test_handshake();
        test_reset_mid();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
